// File: rtl/prim_iter_unit.sv
// Multi-cycle integer sequence unit: sum 1..n, n!, Fibonacci F(n) or 2^n,
// one iteration per clock, with saturating DATA_W-bit result and 4-phase handshake.
module prim_iter_unit #(
  parameter int DATA_W = 32,
  parameter int N_W    = 6
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              en_i,
  input  logic [N_W-1:0]    sw_i,
  input  logic [1:0]        mode_i,
  output logic [DATA_W-1:0] result_o,
  output logic              ovf_o,
  output logic              busy_o,
  output logic              done_o
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  typedef enum logic [1:0] {
    M_SUM  = 2'd0,
    M_FACT = 2'd1,
    M_FIB  = 2'd2,
    M_POW2 = 2'd3
  } mode_t;

  localparam int                PROD_W   = DATA_W + N_W;
  localparam logic [DATA_W-1:0] ALL_ONES = '1;
  localparam logic [DATA_W-1:0] ONE      = DATA_W'(1);

  state_t            state_reg;
  mode_t             mode_reg;
  logic [N_W-1:0]    cnt_reg;
  logic [DATA_W-1:0] a_reg;
  logic              a_sat_reg;
  logic [DATA_W-1:0] b_reg;
  logic              b_sat_reg;
  logic [DATA_W-1:0] result_reg;
  logic              ovf_reg;
  logic              busy_reg;
  logic              done_reg;

  logic [DATA_W-1:0] a_next;
  logic              a_sat_next;
  logic [DATA_W-1:0] b_next;
  logic              b_sat_next;

  logic [DATA_W-1:0] cnt_ext;
  logic [DATA_W:0]   sum_ext;
  logic [DATA_W:0]   fib_ext;
  logic [PROD_W-1:0] prod_ext;

  // Exact-width candidates; the extra top bits expose overflow of each update.
  assign cnt_ext  = DATA_W'(cnt_reg);
  assign sum_ext  = {1'b0, a_reg} + {1'b0, cnt_ext};
  assign fib_ext  = {1'b0, a_reg} + {1'b0, b_reg};
  assign prod_ext = {{N_W{1'b0}}, a_reg} * {{DATA_W{1'b0}}, cnt_reg};

  function automatic logic [DATA_W-1:0] init_acc(input mode_t m);
    return ((m == M_SUM) || (m == M_FIB)) ? '0 : ONE;
  endfunction

  always_comb begin
    a_next     = a_reg;
    a_sat_next = a_sat_reg;
    b_next     = b_reg;
    b_sat_next = b_sat_reg;
    case (mode_reg)
      M_SUM: begin
        if (a_sat_reg || sum_ext[DATA_W]) begin
          a_next     = ALL_ONES;
          a_sat_next = 1'b1;
        end else begin
          a_next = sum_ext[DATA_W-1:0];
        end
      end
      M_FACT: begin
        if (a_sat_reg || (|prod_ext[PROD_W-1:DATA_W])) begin
          a_next     = ALL_ONES;
          a_sat_next = 1'b1;
        end else begin
          a_next = prod_ext[DATA_W-1:0];
        end
      end
      M_POW2: begin
        if (a_sat_reg || a_reg[DATA_W-1]) begin
          a_next     = ALL_ONES;
          a_sat_next = 1'b1;
        end else begin
          a_next = {a_reg[DATA_W-2:0], 1'b0};
        end
      end
      M_FIB: begin
        // a takes b wholesale, so a saturated b carries its flag into a.
        a_next     = b_reg;
        a_sat_next = b_sat_reg;
        if (a_sat_reg || b_sat_reg || fib_ext[DATA_W]) begin
          b_next     = ALL_ONES;
          b_sat_next = 1'b1;
        end else begin
          b_next = fib_ext[DATA_W-1:0];
        end
      end
      default: begin
        a_next = a_reg;
      end
    endcase
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_reg  <= S_IDLE;
      mode_reg   <= M_SUM;
      cnt_reg    <= '0;
      a_reg      <= '0;
      a_sat_reg  <= 1'b0;
      b_reg      <= '0;
      b_sat_reg  <= 1'b0;
      result_reg <= '0;
      ovf_reg    <= 1'b0;
      busy_reg   <= 1'b0;
      done_reg   <= 1'b0;
    end else begin
      case (state_reg)
        S_IDLE: begin
          if (en_i) begin
            mode_reg  <= mode_t'(mode_i);
            cnt_reg   <= sw_i;
            a_reg     <= init_acc(mode_t'(mode_i));
            a_sat_reg <= 1'b0;
            b_reg     <= ONE;
            b_sat_reg <= 1'b0;
            busy_reg  <= 1'b1;
            state_reg <= S_RUN;
          end
        end
        S_RUN: begin
          if (!en_i) begin
            busy_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end else if (cnt_reg == '0) begin
            result_reg <= a_reg;
            ovf_reg    <= a_sat_reg;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b1;
            state_reg  <= S_DONE;
          end else begin
            a_reg     <= a_next;
            a_sat_reg <= a_sat_next;
            b_reg     <= b_next;
            b_sat_reg <= b_sat_next;
            cnt_reg   <= cnt_reg - N_W'(1);
          end
        end
        S_DONE: begin
          // Held until enable drops: no restart without a low phase.
          if (!en_i) begin
            done_reg  <= 1'b0;
            state_reg <= S_IDLE;
          end
        end
        default: begin
          busy_reg  <= 1'b0;
          done_reg  <= 1'b0;
          state_reg <= S_IDLE;
        end
      endcase
    end
  end

  assign result_o = result_reg;
  assign ovf_o    = ovf_reg;
  assign busy_o   = busy_reg;
  assign done_o   = done_reg;

endmodule

// File: doc/prim_iter_unit.md
# prim_iter_unit

Parametrised multi-cycle arithmetic device: the successor to the fixed 3-bit-switch primitive device on the peripheral side of the RISC-V core. On a level-enable handshake it latches an N_W-bit operand and a 2-bit mode, then computes one of four integer sequences (sum 1..n, n!, Fibonacci F(n), 2^n), one iteration per clock. It presents a saturated DATA_W-bit result with an overflow flag and a done indication that is held until software drops enable.

## Interface
- DATA_W, 32, result and accumulator width (≥ 8)
- N_W, 6, operand width; n ranges 0..2^N_W−1
- clk_i  in  1  clock, rising edge
- rst_ni  in  1  reset, asynchronous, active-low
- en_i  in  1  level enable/start; also the abort and acknowledge signal
- sw_i  in  N_W  operand n
- mode_i  in  2  0=SUM, 1=FACT, 2=FIB, 3=POW2
- result_o  out  DATA_W  last completed result, saturated
- ovf_o  out  1  result_o is saturated (true value ≥ 2^DATA_W)
- busy_o  out  1  computation in progress
- done_o  out  1  result_o valid for the current request

## Operation
- FSM states: IDLE, RUN, DONE. Reset → IDLE; result_o=0, ovf_o=0, busy_o=0, done_o=0; internal registers cleared.
- IDLE: en_i=1 at the clock edge → latch n=sw_i and mode=mode_i, load cnt=n, initialise the accumulator, go to RUN. sw_i and mode_i are ignored at all other times.
- Accumulator initialisation per mode: SUM acc=0; FACT acc=1; POW2 acc=1; FIB a=0, b=1.
- RUN, per cycle, if en_i=0: abort → IDLE. result_o, ovf_o and done_o are unchanged (done_o stays 0).
- RUN, per cycle, else if cnt=0: result_o←acc (a for FIB), ovf_o←its sat bit, go to DONE.
- RUN, per cycle, else: apply one update, then cnt←cnt−1.
- Updates:
  - SUM: acc←acc+cnt
  - FACT: acc←acc×cnt, full DATA_W+N_W product
  - POW2: acc←acc<<1
  - FIB: (a,b)←(b, a+b)
- Saturation:
  - Every value register carries a sat bit.
  - If an update's exact value is ≥ 2^DATA_W, or any operand register is already saturated, the register becomes all-ones with sat=1.
  - Once saturated, a register stays saturated until the next start.
  - FIB: a inherits b's value and sat bit, so a saturated b propagates into a.
- DONE: done_o=1 and result_o/ovf_o are stable. en_i=0 → IDLE, done_o falls. en_i held high keeps DONE; no restart occurs without an en_i low phase (4-phase handshake).
- busy_o=1 exactly while in RUN.
- A new request's result overwrites result_o only on completion. Between requests, result_o holds the previous value.
- Reset asserted in any state immediately returns all outputs to their reset values.

## Timing
- Start sampled at edge k. busy_o is high after edge k. done_o, result_o and ovf_o update at edge k+n+1, so latency is n+1 cycles; n=0 gives 1 cycle.
- busy_o falls on the same edge that done_o rises.
- Abort takes effect at the first RUN edge that samples en_i=0.
- From DONE, done_o falls one edge after en_i is sampled low. A start is accepted on the first edge after that at which en_i=1, so the minimum en_i low time is 1 cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.
- FACT uses one DATA_W×N_W multiply per cycle. This is on the critical path and is acceptable at the target clock.

## Test plan
- Reset and SUM:
  - Assert rst_ni low mid-RUN → all outputs 0 asynchronously.
  - Release, then SUM n=63, en_i=1 → done_o 64 cycles after start, result_o=2016, ovf_o=0.
- FACT boundary:
  - n=12 → 479001600, ovf_o=0.
  - n=13 → result_o=0xFFFFFFFF, ovf_o=1.
  - n=0 → 1 after 1 cycle.
- FIB boundary:
  - n=10 → 55.
  - n=47 → 2971215073, ovf_o=0.
  - n=48 → 0xFFFFFFFF, ovf_o=1.
  - n=0 → 0.
- POW2:
  - n=31 → 0x80000000, ovf_o=0.
  - n=32 → 0xFFFFFFFF, ovf_o=1.
- Handshake:
  - Hold en_i=1 after done → done_o stays 1 and no restart.
  - Drop en_i for 1 cycle, change sw_i/mode_i during RUN → the new run uses the values latched at start only.
- Abort: SUM n=20, drop en_i after 5 RUN cycles → back to IDLE, done_o never rises, result_o keeps the prior value.
